// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: next-PC select encodings,
// fetch address window and the nop used to squash faulting fetches.
package mips_defs;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
   localparam logic [31:0] IM_END_DEFAULT   = 32'h0000_6FFC;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// Next-PC computation for the fetch stage: sequential, branch, j/jal and jr.
// Branch and jump targets are based on the delay-slot PC (PC8D - 4).
module npc_calc
   import mips_defs::*;
(
   input  logic [31:0] PCF,
   input  logic [1:0]  npc_sel,
   input  logic [31:0] PC8D,
   input  logic [15:0] imm16D,
   input  logic [25:0] index26D,
   input  logic [31:0] rsD,
   output logic [31:0] NPC
);

   logic [31:0] pcD4;
   logic [31:0] branchOffset;

   // Delay-slot PC and word-scaled sign-extended branch offset
   always_comb begin
      pcD4         = PC8D - 32'd4;
      branchOffset = {{14{imm16D[15]}}, imm16D, 2'b00};
   end

   // jr targets pass through untouched so misalignment surfaces as a fetch fault
   always_comb begin
      NPC = PCF + 32'd4;
      case (npc_sel_t'(npc_sel))
         NPC_SEQ: NPC = PCF + 32'd4;
         NPC_BR:  NPC = pcD4 + branchOffset;
         NPC_J:   NPC = {pcD4[31:28], index26D, 2'b00};
         NPC_JR:  NPC = rsD;
         default: NPC = PCF + 32'd4;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter register, fetch-address fault check and
// outputs for the F->D pipeline register.
module fetch_stage
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
   parameter logic [31:0] IM_END   = IM_END_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stallF,
   input  logic [1:0]  npc_sel,
   input  logic [31:0] PC8D,
   input  logic [15:0] imm16D,
   input  logic [25:0] index26D,
   input  logic [31:0] rsD,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] i_inst_addr,
   output logic [31:0] InsF,
   output logic [31:0] PC8F,
   output logic        excF
);

   logic [31:0] pcReg = RESET_PC;
   logic [31:0] npc;

   npc_calc npcCalc (
      .PCF      (pcReg),
      .npc_sel  (npc_sel),
      .PC8D     (PC8D),
      .imm16D   (imm16D),
      .index26D (index26D),
      .rsD      (rsD),
      .NPC      (npc)
   );

   // Reset wins over stall; a stalled redirect is re-presented by decode later
   always_ff @(posedge clk) begin
      if (reset)
         pcReg <= RESET_PC;
      else if (!stallF)
         pcReg <= npc;
   end

   // A faulting fetch still drives the address but delivers a nop downstream
   always_comb begin
      i_inst_addr = pcReg;
      PC8F        = pcReg + 32'd8;
      excF        = (pcReg[1:0] != 2'b00) || (pcReg < IM_BASE) || (pcReg > IM_END);
      InsF        = excF ? NOP_INSTR : i_inst_rdata;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; instruction memory returns
// a word derived from its address so the fetched word can be predicted.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallF;
   logic [1:0]  npc_sel;
   logic [31:0] PC8D;
   logic [15:0] imm16D;
   logic [25:0] index26D;
   logic [31:0] rsD;
   logic [31:0] i_inst_rdata;
   logic [31:0] i_inst_addr;
   logic [31:0] InsF;
   logic [31:0] PC8F;
   logic        excF;

   int compared   = 0;
   int mismatched = 0;

   localparam logic [31:0] MEM_PATTERN = 32'hA5A5_0000;

   fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .stallF       (stallF),
      .npc_sel      (npc_sel),
      .PC8D         (PC8D),
      .imm16D       (imm16D),
      .index26D     (index26D),
      .rsD          (rsD),
      .i_inst_rdata (i_inst_rdata),
      .i_inst_addr  (i_inst_addr),
      .InsF         (InsF),
      .PC8F         (PC8F),
      .excF         (excF)
   );

   always #5 clk = ~clk;

   assign i_inst_rdata = i_inst_addr ^ MEM_PATTERN;

   // Expected {addr, pc8, exc, ins} for a given PC and fault flag
   function automatic logic [96:0] expVec(input logic [31:0] pc, input logic exc);
      return {pc, pc + 32'd8, exc, exc ? 32'h0 : (pc ^ MEM_PATTERN)};
   endfunction

   function automatic logic [96:0] obsVec();
      return {i_inst_addr, PC8F, excF, InsF};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic [1:0] sel,
                                input logic [31:0] pc8, input logic [15:0] imm,
                                input logic [25:0] idx, input logic [31:0] rs);
      reset = r; stallF = s; npc_sel = sel;
      PC8D = pc8; imm16D = imm; index26D = idx; rsD = rs;
   endtask

   task automatic test_reset();
      logic [96:0] e;
      applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
      tick();
      e = expVec(32'h3000, 1'b0);
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL reset_state: got %h required %h", obsVec(), e);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] seqPc [3] = '{32'h3004, 32'h3008, 32'h300C};
      logic [96:0] e;
      applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         e = expVec(seqPc[i], 1'b0);
         compared++;
         if (obsVec() !== e) begin
            mismatched++;
            $display("[TB] FAIL seq_%0d: got %h required %h", i, obsVec(), e);
         end
      end
   endtask

   task automatic test_stall();
      logic [96:0] e;
      applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
      tick();
      tick();
      applyStimulus(1'b0, 1'b1, 2'd2, 32'h3008, 16'h0, 26'h0000C05, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         e = expVec(32'h3008, 1'b0);
         compared++;
         if (obsVec() !== e) begin
            mismatched++;
            $display("[TB] FAIL stall_hold_%0d: got %h required %h", i, obsVec(), e);
         end
      end
      stallF = 1'b0;
      tick();
      e = expVec(32'h3014, 1'b0);
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL stall_release_jump: got %h required %h", obsVec(), e);
      end
   endtask

   task automatic test_branch();
      logic [96:0] e;
      applyStimulus(1'b0, 1'b0, 2'd1, 32'h3010, 16'hFFFE, 26'h0, 32'h0);
      tick();
      e = expVec(32'h3004, 1'b0);
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL branch_back: got %h required %h", obsVec(), e);
      end
      applyStimulus(1'b0, 1'b0, 2'd1, 32'h3010, 16'h0003, 26'h0, 32'h0);
      tick();
      e = expVec(32'h3018, 1'b0);
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL branch_fwd: got %h required %h", obsVec(), e);
      end
   endtask

   task automatic test_jump();
      logic [96:0] e;
      applyStimulus(1'b0, 1'b0, 2'd2, 32'h3008, 16'h0, 26'h0000C05, 32'h0);
      tick();
      e = expVec(32'h3014, 1'b0);
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL jump: got %h required %h", obsVec(), e);
      end
      // Upper nibble comes from the delay-slot PC, here landing out of range
      applyStimulus(1'b0, 1'b0, 2'd2, 32'h9000_0010, 16'h0, 26'h0000C05, 32'h0);
      tick();
      e = expVec(32'h9000_3014, 1'b1);
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL jump_region: got %h required %h", obsVec(), e);
      end
   endtask

   task automatic test_jr_fault();
      logic [31:0] rsVals [6] = '{32'h3002, 32'h7000, 32'h6FFC, 32'h2FFC, 32'h3000, 32'h7001};
      logic        excVals [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [96:0] e;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 2'd3, 32'h0, 16'h0, 26'h0, rsVals[i]);
         tick();
         e = expVec(rsVals[i], excVals[i]);
         compared++;
         if (obsVec() !== e) begin
            mismatched++;
            $display("[TB] FAIL jr_%0d: got %h required %h", i, obsVec(), e);
         end
      end
   endtask

   task automatic test_wrap();
      logic [96:0] e;
      applyStimulus(1'b0, 1'b0, 2'd3, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
      tick();
      e = {32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 32'h0};
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL wrap_pc8: got %h required %h", obsVec(), e);
      end
      applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
      tick();
      e = expVec(32'h0, 1'b1);
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL wrap_seq: got %h required %h", obsVec(), e);
      end
   endtask

   task automatic test_reset_priority();
      logic [96:0] e;
      applyStimulus(1'b0, 1'b0, 2'd3, 32'h0, 16'h0, 26'h0, 32'h3400);
      tick();
      e = expVec(32'h3400, 1'b0);
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL prio_setup: got %h required %h", obsVec(), e);
      end
      applyStimulus(1'b1, 1'b1, 2'd3, 32'h0, 16'h0, 26'h0, 32'h5000);
      tick();
      e = expVec(32'h3000, 1'b0);
      compared++;
      if (obsVec() !== e) begin
         mismatched++;
         $display("[TB] FAIL reset_priority: got %h required %h", obsVec(), e);
      end
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
      #2;
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_jump();
      test_jr_fault();
      test_wrap();
      test_reset_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
